exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 24 ++
 rtl/exec_ctrl_regfile.sv | 45 ++++
 rtl/exec_ctrl.sv | 95 +++++++++
 tb/tb_exec_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared constants for the execute controller: datapath width, opcodes,
// register-file geometry and FSM state encoding.
package exec_ctrl_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_AW    = $clog2(NUM_REGS);

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_MUL = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/exec_ctrl_regfile.sv
// 8-entry register file: one write port, two operand ports captured on an
// enable, one combinational debug port. r0 always reads zero.
module exec_ctrl_regfile #(
    parameter int WORD_SIZE = exec_ctrl_pkg::WORD_SIZE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [exec_ctrl_pkg::REG_AW-1:0]  waddr,
    input  logic [WORD_SIZE-1:0]              wdata,
    input  logic                              cap,
    input  logic [exec_ctrl_pkg::REG_AW-1:0]  raddr1,
    input  logic [exec_ctrl_pkg::REG_AW-1:0]  raddr2,
    output logic [WORD_SIZE-1:0]              rdata1,
    output logic [WORD_SIZE-1:0]              rdata2,
    input  logic [exec_ctrl_pkg::REG_AW-1:0]  dbg_addr,
    output logic [WORD_SIZE-1:0]              dbg_data
);
    import exec_ctrl_pkg::*;

    logic [WORD_SIZE-1:0] mem [NUM_REGS];

    function automatic logic [WORD_SIZE-1:0] rd_port(input logic [REG_AW-1:0] a);
        return (a == '0) ? '0 : mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (we && waddr != '0) mem[waddr] <= wdata;
            // Operands are sampled from pre-edge contents; a write never
            // coincides with a capture because writes only happen in WB.
            if (cap) begin
                rdata1 <= rd_port(raddr1);
                rdata2 <= rd_port(raddr2);
            end
        end
    end

    assign dbg_data = rd_port(dbg_addr);

endmodule

// File: rtl/exec_ctrl.sv
// Three-state issue/writeback controller sitting in front of a registered ALU.
// ALU ops take IDLE->ISSUE->WB; LDI goes straight to WB; illegal ops set a sticky flag.
module exec_ctrl #(
    parameter int WORD_SIZE = exec_ctrl_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [2:0]           instr_rd,
    input  logic [2:0]           instr_rs1,
    input  logic [2:0]           instr_rs2,
    input  logic [WORD_SIZE-1:0] instr_imm,
    output logic [3:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    output logic                 alu_enable,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 wb_valid,
    output logic [2:0]           wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 err_illegal,
    input  logic [2:0]           dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);
    import exec_ctrl_pkg::*;

    state_t               state;
    logic                 ldi_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic                 cap;

    assign instr_ready = (state == IDLE);
    // Operands are only captured for ALU ops so alu_in1/alu_in2 hold between issues.
    assign cap         = instr_valid && instr_ready && is_alu_op(instr_op);
    assign wb_data     = (state == WB) ? (ldi_q ? imm_q : alu_out) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_enable  <= 1'b0;
            alu_op      <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            err_illegal <= 1'b0;
            ldi_q       <= 1'b0;
            imm_q       <= '0;
        end else begin
            alu_enable <= 1'b0;
            wb_valid   <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    if (is_alu_op(instr_op)) begin
                        state      <= ISSUE;
                        alu_enable <= 1'b1;
                        alu_op     <= instr_op;
                        ldi_q      <= 1'b0;
                        wb_rd      <= instr_rd;
                    end else if (instr_op == OP_LDI) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                        ldi_q    <= 1'b1;
                        imm_q    <= instr_imm;
                        wb_rd    <= instr_rd;
                    end else begin
                        err_illegal <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WB;
                    wb_valid <= 1'b1;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    exec_ctrl_regfile #(.WORD_SIZE(WORD_SIZE)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state == WB),
        .waddr    (wb_rd),
        .wdata    (wb_data),
        .cap      (cap),
        .raddr1   (instr_rs1),
        .raddr2   (instr_rs2),
        .rdata1   (alu_in1),
        .rdata2   (alu_in2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl paired with a registered ALU model.
module tb_exec_ctrl;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, LDI = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic [15:0] instr_imm;
    logic [3:0]  alu_op;
    logic [15:0] alu_in1, alu_in2;
    logic        alu_enable;
    logic [15:0] alu_out = '0;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err_illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    exec_ctrl #(.WORD_SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_enable(alu_enable), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Downstream ALU: result registered on the alu_enable edge.
    always @(posedge clk) begin
        if (alu_enable) begin
            case (alu_op)
                ADD:     alu_out <= alu_in1 + alu_in2;
                SUB:     alu_out <= alu_in1 - alu_in2;
                MUL:     alu_out <= alu_in1 * alu_in2;
                default: alu_out <= '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction end to end; old = r[rd] before the write, a1/a2 = operands.
    task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm, input logic [15:0] exp,
                       input logic [15:0] old, input logic [15:0] a1, input logic [15:0] a2,
                       input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, instr_ready, 1);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (op != LDI) begin
            chk({tag, "_alu_en"}, alu_enable, 1);
            chk({tag, "_alu_op"}, alu_op, op);
            chk({tag, "_in1"}, alu_in1, a1);
            chk({tag, "_in2"}, alu_in2, a2);
            chk({tag, "_no_wb_issue"}, wb_valid, 0);
            @(posedge clk); #1;
        end
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_wb_rd"}, wb_rd, rd);
        chk({tag, "_wb_data"}, wb_data, exp);
        chk({tag, "_wb_alu_en"}, alu_enable, 0);
        dbg_addr = rd; #1;
        chk({tag, "_dbg_old"}, dbg_data, old);
        @(posedge clk); #1;
        chk({tag, "_wb_done"}, wb_valid, 0);
        chk({tag, "_ready_after"}, instr_ready, 1);
        chk({tag, "_dbg_new"}, dbg_data, (rd == 3'd0) ? 16'h0 : exp);
    endtask

    initial begin
        int n_acc, n_wb, last_acc;
        logic acc;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; dbg_addr = '0;
        #12;
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_en", alu_enable, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        dbg_addr = 3'd1; #1;
        chk("rst_dbg_r1", dbg_data, 0);
        @(negedge clk); rst_n = 1'b1;

        run(LDI, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 16'h0, 16'h0, 16'h0, "ldi_r1");
        run(LDI, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0003, 16'h0, 16'h0, 16'h0, "ldi_r2");
        run(ADD, 3'd3, 3'd1, 3'd2, 16'h0, 16'h0008, 16'h0, 16'h0005, 16'h0003, "add");
        run(SUB, 3'd4, 3'd2, 3'd1, 16'h0, 16'hFFFE, 16'h0, 16'h0003, 16'h0005, "sub");
        chk("hold_alu_op", alu_op, SUB);
        chk("hold_in1", alu_in1, 16'h0003);
        chk("hold_alu_en", alu_enable, 0);
        run(LDI, 3'd5, 3'd0, 3'd0, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, "ldi_r5");
        run(LDI, 3'd6, 3'd0, 3'd0, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, "ldi_r6");
        chk("ldi_keeps_in1", alu_in1, 16'h0003);
        run(MUL, 3'd7, 3'd5, 3'd6, 16'h0, 16'h0000, 16'h0, 16'h0100, 16'h0100, "mul");
        run(LDI, 3'd0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h0, 16'h0, 16'h0, "ldi_r0");
        run(ADD, 3'd7, 3'd0, 3'd1, 16'h0, 16'h0005, 16'h0, 16'h0000, 16'h0005, "add_r0");

        // Illegal opcode: flag from the next cycle, no writeback, still ready.
        @(negedge clk);
        instr_op = 4'h7; instr_rd = 3'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("ill_err", err_illegal, 1);
        chk("ill_ready", instr_ready, 1);
        chk("ill_no_wb", wb_valid, 0);
        chk("ill_no_alu", alu_enable, 0);
        @(posedge clk); #1;
        chk("ill_no_wb2", wb_valid, 0);
        run(ADD, 3'd6, 3'd1, 3'd2, 16'h0, 16'h0008, 16'h0100, 16'h0005, 16'h0003, "add_after_ill");
        chk("ill_sticky", err_illegal, 1);

        // Reset in the middle of ISSUE aborts the ADD.
        @(negedge clk);
        instr_op = ADD; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("abort_issue", alu_enable, 1);
        rst_n = 1'b0; #1;
        chk("abort_alu_en", alu_enable, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_err", err_illegal, 0);
        dbg_addr = 3'd3; #1;
        chk("abort_dbg_r3", dbg_data, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_wb", wb_valid, 0);
        end
        chk("abort_dbg_r3_after", dbg_data, 0);

        // Back-to-back ADD r1,r1,r1 with instr_valid held high.
        run(LDI, 3'd1, 3'd0, 3'd0, 16'h0001, 16'h0001, 16'h0, 16'h0, 16'h0, "ldi_b2b");
        @(negedge clk);
        instr_op = ADD; instr_rd = 3'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd1; instr_valid = 1'b1;
        n_acc = 0; n_wb = 0; last_acc = 0;
        for (int cyc = 0; cyc < 20 && n_wb < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            acc = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc > 1) chk("b2b_gap", cyc - last_acc, 3);
                last_acc = cyc;
                if (n_acc == 3) instr_valid = 1'b0;
            end
            if (wb_valid) begin
                chk("b2b_result", wb_data, 16'h0002 << n_wb);
                n_wb++;
            end
        end
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_writebacks", n_wb, 3);
        dbg_addr = 3'd1;
        @(posedge clk); #1;
        chk("b2b_dbg_r1", dbg_data, 16'h0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
